// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI receive path.
// Provides the receiver state encoding and sample-edge selection.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } rx_state_t;

  // Rising edge samples when CPOL == CPHA.
  function automatic logic sample_on_rise(
    input logic cpol,
    input logic cpha
  );
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO, count-based full/empty.
// Ports: push/wdata/full in, pop/rdata/empty out, count = words held.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign count = cnt;
  assign rdata = mem[rp];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_word_rx.sv
// spi_word_rx: oversampled SPI word receiver with FIFO and error flags.
// Ports: sck/sdi/cs pins in; rx_data/rx_valid/rx_ready out; frame_err, overflow, busy.
module spi_word_rx
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             sdi,
  input  logic             cs,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overflow,
  input  logic             clear_ovf,
  output logic             busy
);

  localparam bit RISE = sample_on_rise(CPOL, CPHA);
  localparam int CW   = $clog2(WIDTH);
  localparam int NW   = $clog2(DEPTH) + 1;

  logic [2:0] sck_q;
  logic [1:0] sdi_q;
  logic [1:0] cs_q;

  // cs resets high so a frame live at reset release is not mistaken
  // for idle before the synchroniser has filled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q <= {3{CPOL}};
      sdi_q <= '0;
      cs_q  <= 2'b11;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      sdi_q <= {sdi_q[0], sdi};
      cs_q  <= {cs_q[0], cs};
    end
  end

  logic sck_s;
  logic sck_p;
  logic sdi_s;
  logic cs_s;
  logic samp;

  assign sck_s = sck_q[1];
  assign sck_p = sck_q[2];
  assign sdi_s = sdi_q[1];
  assign cs_s  = cs_q[1];
  assign samp  = RISE ? (sck_s & ~sck_p) : (~sck_s & sck_p);

  rx_state_t        state_q;
  rx_state_t        state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_nx;
  logic             push;
  logic             ferr_d;
  logic             ferr_q;
  logic             ovf_q;

  assign sh_nx = LSB_FIRST ? {sdi_s, sh_q[WIDTH-1:1]}
                           : {sh_q[WIDTH-2:0], sdi_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (!cs_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (cs_s) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!cs_s) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
          sh_d    = '0;
        end else if (samp) begin
          sh_d = sh_nx;
          if (cnt_q == CW'(WIDTH - 1)) begin
            push  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  logic          full;
  logic          empty;
  logic          pop_ok;
  logic          drop;
  logic [NW-1:0] unused_cnt;

  assign pop_ok = rx_ready & ~empty;
  assign drop   = push & full & ~pop_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (sh_nx),
    .full    (full),
    .pop     (rx_ready),
    .rdata   (rx_data),
    .empty   (empty),
    .count   (unused_cnt)
  );

  assign rx_valid  = ~empty;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_word_rx.sv
// tb_spi_word_rx: directed checks of spi_word_rx in all SPI modes.
// Main instance is mode 0 MSB-first; four LSB-first instances cover CPOL/CPHA.
module tb_spi_word_rx;

  localparam int H = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       sck;
  logic       sdi;
  logic       cs;
  logic       rx_ready;
  logic       clear_ovf;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  logic [3:0] sckm;
  logic [3:0] rdym;
  logic [3:0] vm;
  logic [3:0] fm;
  logic [3:0] om;
  logic [3:0] bm;
  logic [7:0] dm [4];

  spi_word_rx #(
    .WIDTH(8), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .cs(cs),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overflow(overflow),
    .clear_ovf(clear_ovf), .busy(busy)
  );

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_word_rx #(
      .WIDTH(8), .DEPTH(4), .CPOL(m >= 2), .CPHA((m % 2) == 1),
      .LSB_FIRST(1'b1)
    ) u (
      .clk(clk), .reset_n(reset_n), .sck(sckm[m]), .sdi(sdi), .cs(cs),
      .rx_data(dm[m]), .rx_valid(vm[m]), .rx_ready(rdym[m]),
      .frame_err(fm[m]), .overflow(om[m]),
      .clear_ovf(clear_ovf), .busy(bm[m])
    );
  end

  int         n_chk = 0;
  int         n_fail = 0;
  int         ferr_main = 0;
  int         ferr_mode = 0;
  int         busy_low = 0;
  bit         in_frame = 1'b0;
  logic [7:0] hs_q [$];

  always @(posedge clk) begin
    if (frame_err) ferr_main++;
    if (|fm) ferr_mode++;
    if (in_frame && !busy) busy_low++;
    if (rx_valid && rx_ready) hs_q.push_back(rx_data);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_valid(input int w);
    if (w == 4) return rx_valid;
    return vm[w];
  endfunction

  function automatic logic [7:0] get_data(input int w);
    if (w == 4) return rx_data;
    return dm[w];
  endfunction

  task automatic set_sck(input int w, input logic v);
    if (w == 4) sck = v;
    else sckm[w] = v;
  endtask

  task automatic pop(input int w);
    if (w == 4) rx_ready = 1'b1;
    else rdym[w] = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    rdym = '0;
  endtask

  // Sends s[n-1] first; target 4 is the main instance (mode 0).
  task automatic send_bits(input int w, input logic [31:0] s, input int n);
    bit cpol;
    bit cpha;
    cpol = (w < 4) && (w >= 2);
    cpha = (w < 4) && ((w % 2) == 1);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        sdi = s[i];
        wait_clk(H);
        set_sck(w, ~cpol);
        wait_clk(H);
        set_sck(w, cpol);
      end else begin
        set_sck(w, ~cpol);
        sdi = s[i];
        wait_clk(H);
        set_sck(w, cpol);
        wait_clk(H);
      end
    end
  endtask

  task automatic cs_up();
    cs = 1'b1;
    wait_clk(H);
    in_frame = 1'b1;
  endtask

  task automatic cs_down();
    wait_clk(H);
    in_frame = 1'b0;
    cs = 1'b0;
    wait_clk(2 * H);
  endtask

  // Final mode-0 bit of the main instance, with the pin edge right after
  // posedge P: the word lands at P+3, so a posedge consumer sees it at P+4.
  task automatic last_edge(input logic b, input bit chk, input bit pop_now);
    sdi = b;
    wait_clk(H);
    sck = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (pop_now) rx_ready = 1'b1;
    @(negedge clk);
    if (chk) check("lat_before", rx_valid, 1'b0);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    if (chk) check("lat_after", rx_valid, 1'b1);
    wait_clk(H - 3);
    sck = 1'b0;
  endtask

  typedef struct {
    int         w;
    logic [7:0] s;
    logic [7:0] e;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] exp_q [4];
  int         f0;

  initial begin
    vecs[0] = '{4, 8'h3C, 8'h3C};
    vecs[1] = '{4, 8'hFF, 8'hFF};
    vecs[2] = '{0, 8'hB0, 8'h0D};
    vecs[3] = '{1, 8'hB0, 8'h0D};
    vecs[4] = '{2, 8'hB0, 8'h0D};
    vecs[5] = '{3, 8'hB0, 8'h0D};
    vecs[6] = '{0, 8'hC1, 8'h83};
    vecs[7] = '{1, 8'hC1, 8'h83};
    vecs[8] = '{2, 8'hC1, 8'h83};
    vecs[9] = '{3, 8'hC1, 8'h83};

    reset_n = 1'b0;
    sck = 1'b0;
    sckm = 4'b1100;
    sdi = 1'b0;
    cs = 1'b0;
    rx_ready = 1'b0;
    rdym = '0;
    clear_ovf = 1'b0;
    wait_clk(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_modes", {vm, om, bm}, 12'h000);
    reset_n = 1'b1;
    wait_clk(H);

    cs_up();
    send_bits(4, 8'h52, 7);
    last_edge(1'b1, 1'b1, 1'b0);
    cs_down();
    check("a5_data", rx_data, 8'hA5);
    check("a5_ferr", ferr_main, 0);
    pop(4);
    check("a5_popped", rx_valid, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cs_up();
      send_bits(vecs[i].w, 32'(vecs[i].s), 8);
      cs_down();
      check($sformatf("vec%0d_valid", i), get_valid(vecs[i].w), 1'b1);
      check($sformatf("vec%0d_data", i), get_data(vecs[i].w), vecs[i].e);
      pop(vecs[i].w);
      check($sformatf("vec%0d_pop", i), get_valid(vecs[i].w), 1'b0);
    end
    check("vec_ferr_main", ferr_main, 0);
    check("vec_ferr_mode", ferr_mode, 0);

    hs_q.delete();
    busy_low = 0;
    rx_ready = 1'b1;
    cs_up();
    send_bits(4, 8'h11, 8);
    send_bits(4, 8'h22, 8);
    send_bits(4, 8'h33, 8);
    cs_down();
    rx_ready = 1'b0;
    check("multi_count", hs_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("multi_w%0d", i),
            (i < hs_q.size()) ? hs_q[i] : 8'hxx, 8'(8'h11 * (i + 1)));
    end
    check("multi_busy_low", busy_low, 0);
    check("multi_busy_end", busy, 1'b0);

    cs_up();
    for (int k = 0; k < 5; k++) send_bits(4, 32'(8'hC0 + k), 8);
    cs_down();
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", rx_data, 8'hC0);
    clear_ovf = 1'b1;
    wait_clk(1);
    clear_ovf = 1'b0;
    check("ovf_clear", overflow, 1'b0);
    cs_up();
    send_bits(4, 8'h6A, 7);
    last_edge(1'b1, 1'b0, 1'b1);
    cs_down();
    check("ovf_pushpop", overflow, 1'b0);
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hD5};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovf_q%0d", k), rx_data, exp_q[k]);
      pop(4);
    end
    check("ovf_empty", rx_valid, 1'b0);

    cs_up();
    send_bits(4, 8'h5A, 8);
    cs_down();
    f0 = ferr_main;
    cs_up();
    send_bits(4, 32'h16, 5);
    wait_clk(H);
    in_frame = 1'b0;
    cs = 1'b0;
    repeat (3) @(negedge clk);
    check("ferr_early", frame_err, 1'b0);
    @(negedge clk);
    check("ferr_pulse", frame_err, 1'b1);
    @(negedge clk);
    check("ferr_end", frame_err, 1'b0);
    wait_clk(2 * H);
    check("ferr_count", ferr_main - f0, 1);
    check("ferr_fifo_v", rx_valid, 1'b1);
    check("ferr_fifo_d", rx_data, 8'h5A);
    pop(4);
    cs_up();
    send_bits(4, 8'h3C, 8);
    cs_down();
    check("after_ferr", rx_data, 8'h3C);
    pop(4);

    cs_up();
    send_bits(4, 8'h71, 8);
    send_bits(4, 8'h72, 8);
    cs_down();
    check("pre_rst_valid", rx_valid, 1'b1);
    f0 = ferr_main;
    cs = 1'b1;
    wait_clk(H);
    send_bits(4, 32'h5, 3);
    reset_n = 1'b0;
    wait_clk(2);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    reset_n = 1'b1;
    send_bits(4, 32'h06, 5);
    send_bits(4, 8'hEE, 8);
    wait_clk(H);
    check("ignored_busy", busy, 1'b0);
    check("ignored_valid", rx_valid, 1'b0);
    cs = 1'b0;
    wait_clk(2 * H);
    check("ignored_ferr", ferr_main - f0, 0);
    cs_up();
    send_bits(4, 8'h96, 8);
    cs_down();
    check("post_rst_valid", rx_valid, 1'b1);
    check("post_rst_data", rx_data, 8'h96);
    pop(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_word_rx.md
# spi_word_rx

Parametrised SPI receive port that replaces the single-byte, sck-clocked shifter with a word receiver running in the system clock domain. It oversamples `sck`, `sdi` and `cs` through synchronisers and supports all four CPOL/CPHA modes plus MSB- or LSB-first order. It frames words of configurable width and buffers completed words in a small FIFO with a valid/ready handshake. It sits between the MCU SPI pins and the FPGA signal-processing logic, and provides overflow and framing-error reporting.

## Interface
Parameters:
- `WIDTH`, 8: bits per word (2..32).
- `DEPTH`, 4: FIFO depth in words (power of two, ≥2).
- `CPOL`, 0: idle level of `sck`.
- `CPHA`, 0: sampling phase.
- `LSB_FIRST`, 0: 0 = first bit is the MSB; 1 = first bit is the LSB.

Ports:
- `clk` in 1: system clock; must be ≥4× the `sck` frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `sck` in 1: SPI clock, asynchronous to `clk`.
- `sdi` in 1: SPI data in, asynchronous to `clk`.
- `cs` in 1: chip select, active-high; a frame is a `cs` high interval.
- `rx_data` out WIDTH: FIFO head word.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts the head word when `rx_valid & rx_ready`.
- `frame_err` out 1: one-cycle pulse when `cs` drops with a partial word.
- `overflow` out 1: sticky; set when a completed word is dropped.
- `clear_ovf` in 1: synchronous clear of `overflow`.
- `busy` out 1: high while in ACTIVE.

## Operation
- **Synchronisation and edge detection**
  - `sck`, `sdi` and `cs` each pass through a 2-flop synchroniser.
  - A third flop on `sck` provides edge detection.
- **Sample edge**
  - The rising edge is the sample edge when CPOL==CPHA; otherwise the falling edge is the sample edge.
  - The other edge is ignored.
- **State machine**
  - WAIT_IDLE: entered on reset. Moves to IDLE once synced `cs` is seen low. A frame already in progress at reset release is therefore ignored.
  - IDLE: bit counter = 0. Synced `cs` rising moves to ACTIVE.
  - ACTIVE: on each sample edge, shift in synced `sdi` and increment the counter.
    - MSB-first shifts left, inserting at bit 0.
    - LSB-first shifts right, inserting at bit WIDTH-1.
  - Word completion: at counter = WIDTH-1 plus a sample edge, the completed word is pushed to the FIFO and the counter returns to 0. The block stays in ACTIVE, so multi-word frames are supported.
  - Synced `cs` falling in ACTIVE:
    - If the counter ≠ 0: pulse `frame_err`, discard the partial word, go to IDLE.
    - If the counter = 0: go to IDLE silently.
- **FIFO**
  - Push: a word is written unless the FIFO is full with no pop in the same cycle. Simultaneous push and pop while full is legal and nothing is lost.
  - Drop: if full with no pop, the word is dropped and `overflow` is set.
  - Overflow priority: `overflow` set wins over `clear_ovf` in the same cycle.
  - Pointers: read and write pointers wrap modulo DEPTH. Full and empty are distinguished by a count register of width $clog2(DEPTH)+1.
  - Output: `rx_data` is the registered head word. It is undefined-but-stable while `rx_valid` is low.
- **Reset values**
  - All outputs reset to 0.
  - The FIFO is emptied, the state is WAIT_IDLE and the shift register is 0.
  - Reset mid-frame loses all buffered and partial data.

## Timing
- Pin-to-detect: the sample edge at the pin is detected 3 `clk` cycles later (2 sync stages, 1 edge flop).
- Push latency: the push occurs in the detect cycle. `rx_valid` rises the following cycle, 4 `clk` cycles after the pin edge, when the FIFO was empty.
- Pop: registered. `rx_valid` and `rx_data` update the cycle after the handshake.
  - Back-to-back pops at 1 word/clk are sustained.
- `frame_err` pulses for exactly 1 cycle, 3 `clk` cycles after `cs` falls at the pin.
- `busy` follows the state with no added latency.
- Minimum `cs` low time between frames: 3 `clk` cycles.

## Structure
- Package `spi_pkg`:
  - `rx_state_t` enum: WAIT_IDLE, IDLE, ACTIVE.
  - `function sample_on_rise(CPOL, CPHA)`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/full, pop/empty, count).
  - Reusable for a future transmit path.
- Top level contains the synchronisers, edge detect, FSM, shift register and bit counter.

## Test plan
- Mode 0, WIDTH=8, MSB-first: frame 0xA5 → `rx_data`=0xA5, `rx_valid` rises 4 clk after the 8th rising `sck`, no `frame_err`.
- LSB_FIRST=1, sample edges on all four CPOL/CPHA combinations: bit stream 1,0,1,1,0,0,0,0 → `rx_data`=0x0D in every mode.
- One `cs` frame of 3 words 0x11, 0x22, 0x33 with `rx_ready`=1 → three handshakes in order, `busy` high throughout.
- DEPTH=4, `rx_ready`=0, 5 words → first 4 retained, 5th dropped, `overflow`=1. `clear_ovf` → 0. Then a push and pop in the same cycle while full → no overflow.
- `cs` drops after 5 of 8 bits → `frame_err` 1-cycle pulse, FIFO unchanged. The next full frame 0x3C is received correctly.
- `reset_n` asserted mid-frame with 2 words buffered → `rx_valid`=0. After release, the remainder of the interrupted frame is ignored until `cs` goes low, and the next frame is received normally.
